mc_exec_unit: RTL and testbench



---
 rtl/exec_pkg.sv | 44 ++++
 rtl/mc_alu_comb.sv | 64 ++++++
 rtl/mc_exec_unit.sv | 216 +++++++++++++++++++++
 tb/tb_mc_exec_unit.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared types for the multi-cycle execution unit: function codes, FSM states,
// the flag bundle and a constant-evaluable log2 helper.
package exec_pkg;

    typedef enum logic [3:0] {
        F_ADD   = 4'd0,
        F_SUB   = 4'd1,
        F_AND   = 4'd2,
        F_OR    = 4'd3,
        F_NEG   = 4'd4,
        F_CMP   = 4'd5,
        F_PASSX = 4'd6,
        F_PASSY = 4'd7,
        F_SHL   = 4'd8,
        F_SHR   = 4'd9,
        F_SAR   = 4'd10,
        F_MUL   = 4'd11
    } fsel_e;

    localparam logic [3:0] FSEL_LAST_LEGAL = 4'd11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_ITER,
        S_DONE
    } state_e;

    typedef struct packed {
        logic c;
        logic v;
        logic s;
        logic z;
    } flags_t;

    // Smallest r with 2**r >= n; usable in parameter expressions.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/mc_alu_comb.sv
// Single-cycle ALU: add/sub family through one shared adder, logic ops and
// operand passes, with carry/overflow/sign/zero flags.
module mc_alu_comb
    import exec_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [3:0]       i_fsel,
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    output logic [WIDTH-1:0] o_result,
    output flags_t           o_flags
);

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic             w_cin;
    logic [WIDTH:0]   w_sum;
    logic             w_ovf;

    // Subtraction forms are X + ~Y + 1, so carry out means "no borrow".
    always_comb begin
        w_a   = i_x;
        w_b   = i_y;
        w_cin = 1'b0;
        case (i_fsel)
            F_SUB, F_CMP: begin
                w_b   = ~i_y;
                w_cin = 1'b1;
            end
            F_NEG: begin
                w_a   = '0;
                w_b   = ~i_x;
                w_cin = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_sum = {1'b0, w_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_cin};
    assign w_ovf = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        o_result  = '0;
        o_flags.c = 1'b0;
        o_flags.v = 1'b0;
        case (i_fsel)
            F_ADD, F_SUB, F_CMP, F_NEG: begin
                o_result  = w_sum[WIDTH-1:0];
                o_flags.c = w_sum[WIDTH];
                o_flags.v = w_ovf;
            end
            F_AND:   o_result = i_x & i_y;
            F_OR:    o_result = i_x | i_y;
            F_PASSX: o_result = i_x;
            F_PASSY: o_result = i_y;
            default: ;
        endcase
        o_flags.s = o_result[WIDTH-1];
        o_flags.z = (o_result == '0);
    end

endmodule

// File: rtl/mc_exec_unit.sv
// Multi-cycle execute stage: register file, single-cycle ALU and a bit-serial
// shift/multiply engine sequenced by a four-state handshake FSM.
module mc_exec_unit
    import exec_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int NREGS = 8,
    localparam int RA_W  = clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [3:0]       op_fsel,
    input  logic [RA_W-1:0]  op_dst,
    input  logic [RA_W-1:0]  op_src1,
    input  logic [RA_W-1:0]  op_src2,
    input  logic             op_imm_en,
    input  logic [WIDTH-1:0] op_imm,
    output logic             res_valid,
    output logic             res_err,
    output logic [WIDTH-1:0] res_data,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_s,
    output logic             flag_z,
    input  logic             ext_wr_en,
    input  logic [RA_W-1:0]  ext_wr_addr,
    input  logic [WIDTH-1:0] ext_wr_data,
    input  logic [RA_W-1:0]  dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    localparam int SA_W  = clog2(WIDTH);
    localparam int CNT_W = clog2(WIDTH + 1);

    state_e             r_state;
    state_e             w_state_next;
    logic [3:0]         r_fsel;
    logic [RA_W-1:0]    r_dst;
    logic [WIDTH-1:0]   r_x;
    logic [WIDTH-1:0]   r_y;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_sh;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_rf [NREGS];
    logic [WIDTH-1:0]   r_res_data;
    flags_t             r_flags;
    logic               r_err;

    logic               w_accept;
    logic               w_is_shift;
    logic               w_is_mul;
    logic               w_legal;
    logic [SA_W-1:0]    w_k;
    logic               w_iter_start;
    logic               w_finish;
    logic               w_wb_en;
    logic [WIDTH-1:0]   w_alu_result;
    flags_t             w_alu_flags;
    logic [WIDTH-1:0]   w_sh_next;
    logic               w_sh_c_next;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_prod_next;
    logic [WIDTH-1:0]   w_fin_data;
    flags_t             w_fin_flags;

    mc_alu_comb #(.WIDTH(WIDTH)) u_alu (
        .i_fsel   (r_fsel),
        .i_x      (r_x),
        .i_y      (r_y),
        .o_result (w_alu_result),
        .o_flags  (w_alu_flags)
    );

    assign w_accept     = op_valid && (r_state == S_IDLE);
    assign w_is_shift   = (r_fsel == F_SHL) || (r_fsel == F_SHR) || (r_fsel == F_SAR);
    assign w_is_mul     = (r_fsel == F_MUL);
    assign w_legal      = (r_fsel <= FSEL_LAST_LEGAL);
    assign w_k          = r_y[SA_W-1:0];
    assign w_iter_start = (r_state == S_EXEC) && (w_is_mul || (w_is_shift && (w_k != '0)));
    assign w_finish     = ((r_state == S_EXEC) && !w_iter_start) ||
                          ((r_state == S_ITER) && (r_cnt == CNT_W'(1)));
    assign w_wb_en      = w_finish && w_legal && (r_fsel != F_CMP);

    // FSM: state register, next-state logic, output decode.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (op_valid) w_state_next = S_EXEC;
            S_EXEC: w_state_next = w_iter_start ? S_ITER : S_DONE;
            S_ITER: if (r_cnt == CNT_W'(1)) w_state_next = S_DONE;
            S_DONE: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        op_ready  = (r_state == S_IDLE);
        res_valid = (r_state == S_DONE);
        res_err   = (r_state == S_DONE) && r_err;
    end

    // One shift step; the carry is the bit that falls off.
    always_comb begin
        w_sh_next   = r_sh;
        w_sh_c_next = 1'b0;
        case (r_fsel)
            F_SHL: begin
                w_sh_next   = {r_sh[WIDTH-2:0], 1'b0};
                w_sh_c_next = r_sh[WIDTH-1];
            end
            F_SHR: begin
                w_sh_next   = {1'b0, r_sh[WIDTH-1:1]};
                w_sh_c_next = r_sh[0];
            end
            F_SAR: begin
                w_sh_next   = {r_sh[WIDTH-1], r_sh[WIDTH-1:1]};
                w_sh_c_next = r_sh[0];
            end
            default: ;
        endcase
    end

    // Right-shifting shift-add multiply: multiplier sits in the low half and is
    // consumed LSB first while the partial product grows into the high half.
    assign w_mul_sum   = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_x} : '0);
    assign w_prod_next = {w_mul_sum, r_prod[WIDTH-1:1]};

    always_comb begin
        w_fin_data  = w_alu_result;
        w_fin_flags = w_alu_flags;
        if (r_state == S_ITER) begin
            if (w_is_mul) begin
                w_fin_data    = w_prod_next[WIDTH-1:0];
                w_fin_flags.c = |w_prod_next[2*WIDTH-1:WIDTH];
                w_fin_flags.v = |w_prod_next[2*WIDTH-1:WIDTH];
            end else begin
                w_fin_data    = w_sh_next;
                w_fin_flags.c = w_sh_c_next;
                w_fin_flags.v = 1'b0;
            end
            w_fin_flags.s = w_fin_data[WIDTH-1];
            w_fin_flags.z = (w_fin_data == '0);
        end else if (w_is_shift) begin
            w_fin_data    = r_x;
            w_fin_flags.c = 1'b0;
            w_fin_flags.v = 1'b0;
            w_fin_flags.s = r_x[WIDTH-1];
            w_fin_flags.z = (r_x == '0);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so operands
    // latched at accept see the register file as it was before this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fsel     <= '0;
            r_dst      <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_cnt      <= '0;
            r_sh       <= '0;
            r_prod     <= '0;
            r_res_data <= '0;
            r_flags    <= '0;
            r_err      <= 1'b0;
            // NOTE: the register file must read zero after reset, so every
            // entry is cleared here rather than left to power-up contents.
            for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
        end else begin
            if (w_accept) begin
                r_fsel <= op_fsel;
                r_dst  <= op_dst;
                r_x    <= r_rf[op_src1];
                r_y    <= op_imm_en ? op_imm : r_rf[op_src2];
            end

            if (r_state == S_EXEC) begin
                r_cnt  <= w_is_mul ? CNT_W'(WIDTH) : CNT_W'(w_k);
                r_sh   <= r_x;
                r_prod <= {{WIDTH{1'b0}}, r_y};
            end else if (r_state == S_ITER) begin
                r_cnt  <= r_cnt - CNT_W'(1);
                r_sh   <= w_sh_next;
                r_prod <= w_prod_next;
            end

            if (w_finish) begin
                r_err <= !w_legal;
                if (w_legal) begin
                    r_res_data <= w_fin_data;
                    r_flags    <= w_fin_flags;
                end
            end

            // NOTE: the writeback is the later assignment, so it overrides an
            // external write to the same address on the same edge.
            if (ext_wr_en) r_rf[ext_wr_addr] <= ext_wr_data;
            if (w_wb_en)   r_rf[r_dst]       <= w_fin_data;
        end
    end

    assign res_data = r_res_data;
    assign flag_c   = r_flags.c;
    assign flag_v   = r_flags.v;
    assign flag_s   = r_flags.s;
    assign flag_z   = r_flags.z;
    assign dbg_data = r_rf[dbg_addr];

endmodule

// File: tb/tb_mc_exec_unit.sv
// Directed bench for mc_exec_unit: a table of operations with hand-computed
// results, flags and latencies, plus sequences for illegal ops, write
// collisions and reset in the middle of a multiply.
module tb_mc_exec_unit;

    localparam int WIDTH = 16;
    localparam int NREGS = 8;
    localparam int RA_W  = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             op_valid;
    logic             op_ready;
    logic [3:0]       op_fsel;
    logic [RA_W-1:0]  op_dst;
    logic [RA_W-1:0]  op_src1;
    logic [RA_W-1:0]  op_src2;
    logic             op_imm_en;
    logic [WIDTH-1:0] op_imm;
    logic             res_valid;
    logic             res_err;
    logic [WIDTH-1:0] res_data;
    logic             flag_c;
    logic             flag_v;
    logic             flag_s;
    logic             flag_z;
    logic             ext_wr_en;
    logic [RA_W-1:0]  ext_wr_addr;
    logic [WIDTH-1:0] ext_wr_data;
    logic [RA_W-1:0]  dbg_addr;
    logic [WIDTH-1:0] dbg_data;

    always #5 clk = ~clk;

    mc_exec_unit #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
        .clk         (clk),
        .reset       (reset),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_fsel     (op_fsel),
        .op_dst      (op_dst),
        .op_src1     (op_src1),
        .op_src2     (op_src2),
        .op_imm_en   (op_imm_en),
        .op_imm      (op_imm),
        .res_valid   (res_valid),
        .res_err     (res_err),
        .res_data    (res_data),
        .flag_c      (flag_c),
        .flag_v      (flag_v),
        .flag_s      (flag_s),
        .flag_z      (flag_z),
        .ext_wr_en   (ext_wr_en),
        .ext_wr_addr (ext_wr_addr),
        .ext_wr_data (ext_wr_data),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    typedef struct {
        string       name;
        logic [3:0]  fsel;
        logic [15:0] x;
        logic [15:0] y;
        logic        imm_en;
        logic [2:0]  dst;
        logic [15:0] exp_data;
        logic [3:0]  exp_cvsz;
        int          exp_lat;
        logic        exp_wb;
    } vec_t;

    vec_t        vecs[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] mdl_rf [NREGS];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] flags_now();
        return {flag_c, flag_v, flag_s, flag_z};
    endfunction

    task automatic ext_write(input logic [2:0] addr, input logic [15:0] data);
        @(posedge clk);
        #1;
        ext_wr_en   = 1'b1;
        ext_wr_addr = addr;
        ext_wr_data = data;
        @(posedge clk);
        #1;
        ext_wr_en   = 1'b0;
        mdl_rf[addr] = data;
    endtask

    // Issues one op and returns at the negedge of the res_valid cycle;
    // lat counts cycles with the accept edge as cycle 0.
    task automatic run_op(input string name, input logic [3:0] fsel, input logic [2:0] dst,
                          input logic imm_en, input logic [15:0] imm, output int lat);
        @(posedge clk);
        #1;
        op_valid  = 1'b1;
        op_fsel   = fsel;
        op_src1   = 3'd1;
        op_src2   = 3'd2;
        op_dst    = dst;
        op_imm_en = imm_en;
        op_imm    = imm;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        check({name, "_ready_low"}, 32'(op_ready), 32'd0);
        while (!res_valid && lat < 60) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic expect_idle_next(input string name);
        @(posedge clk);
        @(negedge clk);
        check({name, "_ready_back"}, 32'(op_ready), 32'd1);
    endtask

    // ADD r1+r2 -> dst with an external write landing on the writeback edge.
    task automatic coll_op(input string name, input logic [2:0] dst,
                           input logic [2:0] ea, input logic [15:0] ed);
        @(posedge clk);
        #1;
        op_valid  = 1'b1;
        op_fsel   = 4'd0;
        op_src1   = 3'd1;
        op_src2   = 3'd2;
        op_dst    = dst;
        op_imm_en = 1'b0;
        @(posedge clk);
        #1;
        op_valid    = 1'b0;
        ext_wr_en   = 1'b1;
        ext_wr_addr = ea;
        ext_wr_data = ed;
        @(posedge clk);
        #1;
        ext_wr_en = 1'b0;
        @(negedge clk);
        check({name, "_valid"}, 32'(res_valid), 32'd1);
        check({name, "_err"}, 32'(res_err), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [15:0] prev_data;
        logic [3:0]  prev_flags;
        int          pulses;

        reset       = 1'b1;
        op_valid    = 1'b0;
        op_fsel     = '0;
        op_dst      = '0;
        op_src1     = '0;
        op_src2     = '0;
        op_imm_en   = 1'b0;
        op_imm      = '0;
        ext_wr_en   = 1'b0;
        ext_wr_addr = '0;
        ext_wr_data = '0;
        dbg_addr    = '0;
        for (int i = 0; i < NREGS; i++) mdl_rf[i] = '0;

        //             name      fsel   x        y        imm   dst   data     cvsz     lat wb
        vecs.push_back('{"add_ovf",  4'd0,  16'h7FFF, 16'h0001, 1'b0, 3'd3, 16'h8000, 4'b0110, 2,  1'b1});
        vecs.push_back('{"sub_zero", 4'd1,  16'h0005, 16'h0005, 1'b0, 3'd3, 16'h0000, 4'b1001, 2,  1'b1});
        vecs.push_back('{"cmp_lt",   4'd5,  16'h0003, 16'h0005, 1'b0, 3'd4, 16'hFFFE, 4'b0010, 2,  1'b0});
        vecs.push_back('{"sar4",     4'd10, 16'h8000, 16'h0004, 1'b1, 3'd5, 16'hF800, 4'b0010, 6,  1'b1});
        vecs.push_back('{"shr1",     4'd9,  16'h8001, 16'h0001, 1'b1, 3'd5, 16'h4000, 4'b1000, 3,  1'b1});
        vecs.push_back('{"mul_hi",   4'd11, 16'h0100, 16'h0100, 1'b0, 3'd6, 16'h0000, 4'b1101, 18, 1'b1});
        vecs.push_back('{"mul_lo",   4'd11, 16'h0003, 16'h0005, 1'b0, 3'd6, 16'h000F, 4'b0000, 18, 1'b1});
        vecs.push_back('{"and",      4'd2,  16'hF0F0, 16'h3C3C, 1'b0, 3'd7, 16'h3030, 4'b0000, 2,  1'b1});
        vecs.push_back('{"or",       4'd3,  16'hF0F0, 16'h3C3C, 1'b0, 3'd7, 16'hFCFC, 4'b0010, 2,  1'b1});
        vecs.push_back('{"neg1",     4'd4,  16'h0001, 16'h0000, 1'b0, 3'd3, 16'hFFFF, 4'b0010, 2,  1'b1});
        vecs.push_back('{"neg_min",  4'd4,  16'h8000, 16'h0000, 1'b0, 3'd3, 16'h8000, 4'b0110, 2,  1'b1});
        vecs.push_back('{"passx",    4'd6,  16'h1234, 16'h5678, 1'b0, 3'd4, 16'h1234, 4'b0000, 2,  1'b1});
        vecs.push_back('{"passy",    4'd7,  16'h1234, 16'h5678, 1'b0, 3'd4, 16'h5678, 4'b0000, 2,  1'b1});
        vecs.push_back('{"passy_im", 4'd7,  16'h1234, 16'h9ABC, 1'b1, 3'd4, 16'h9ABC, 4'b0010, 2,  1'b1});
        vecs.push_back('{"shl1",     4'd8,  16'hC001, 16'h0001, 1'b1, 3'd5, 16'h8002, 4'b1010, 3,  1'b1});
        vecs.push_back('{"shl_k0",   4'd8,  16'h1234, 16'h0010, 1'b1, 3'd5, 16'h1234, 4'b0000, 2,  1'b1});
        vecs.push_back('{"shl15",    4'd8,  16'h0001, 16'h000F, 1'b1, 3'd5, 16'h8000, 4'b0010, 17, 1'b1});
        vecs.push_back('{"shr4_reg", 4'd9,  16'h00F0, 16'h0004, 1'b0, 3'd6, 16'h000F, 4'b0000, 6,  1'b1});
        vecs.push_back('{"sar1_reg", 4'd10, 16'h7FF1, 16'h0001, 1'b0, 3'd6, 16'h3FF8, 4'b1000, 3,  1'b1});
        vecs.push_back('{"add_wrap", 4'd0,  16'hFFFF, 16'h0001, 1'b0, 3'd7, 16'h0000, 4'b1001, 2,  1'b1});
        vecs.push_back('{"sub_ovf",  4'd1,  16'h8000, 16'h0001, 1'b0, 3'd7, 16'h7FFF, 4'b1100, 2,  1'b1});
        vecs.push_back('{"mul_max",  4'd11, 16'hFFFF, 16'hFFFF, 1'b0, 3'd3, 16'h0001, 4'b1100, 18, 1'b1});
        vecs.push_back('{"sub_imm",  4'd1,  16'h0003, 16'h0005, 1'b1, 3'd3, 16'hFFFE, 4'b0010, 2,  1'b1});

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(op_ready), 32'd1);
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_err", 32'(res_err), 32'd0);
        check("rst_data", 32'(res_data), 32'd0);
        check("rst_flags", 32'(flags_now()), 32'd0);
        for (int i = 0; i < NREGS; i++) begin
            dbg_addr = 3'(i);
            #1;
            check($sformatf("rst_r%0d", i), 32'(dbg_data), 32'd0);
        end

        foreach (vecs[i]) begin
            ext_write(3'd1, vecs[i].x);
            // With an immediate, r2 holds a decoy so a wrong operand path shows.
            ext_write(3'd2, vecs[i].imm_en ? ~vecs[i].y : vecs[i].y);
            run_op(vecs[i].name, vecs[i].fsel, vecs[i].dst, vecs[i].imm_en, vecs[i].y, lat);
            check({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].exp_lat));
            check({vecs[i].name, "_data"}, 32'(res_data), 32'(vecs[i].exp_data));
            check({vecs[i].name, "_cvsz"}, 32'(flags_now()), 32'(vecs[i].exp_cvsz));
            check({vecs[i].name, "_err"}, 32'(res_err), 32'd0);
            if (vecs[i].exp_wb) mdl_rf[vecs[i].dst] = vecs[i].exp_data;
            dbg_addr = vecs[i].dst;
            #1;
            check({vecs[i].name, "_rf"}, 32'(dbg_data), 32'(mdl_rf[vecs[i].dst]));
            expect_idle_next(vecs[i].name);
        end

        // Illegal function code: error pulse, nothing architectural changes.
        prev_data  = 16'hFFFE;
        prev_flags = 4'b0010;
        ext_write(3'd1, 16'h0101);
        ext_write(3'd2, 16'h0202);
        run_op("illegal", 4'd13, 3'd3, 1'b0, 16'h0000, lat);
        check("illegal_lat", 32'(lat), 32'd2);
        check("illegal_err", 32'(res_err), 32'd1);
        check("illegal_data", 32'(res_data), 32'(prev_data));
        check("illegal_cvsz", 32'(flags_now()), 32'(prev_flags));
        dbg_addr = 3'd3;
        #1;
        check("illegal_rf", 32'(dbg_data), 32'(mdl_rf[3]));
        expect_idle_next("illegal");

        // Writeback beats an external write to the same register.
        ext_write(3'd1, 16'h1111);
        ext_write(3'd2, 16'h2222);
        coll_op("coll_same", 3'd2, 3'd2, 16'hAAAA);
        dbg_addr = 3'd2;
        #1;
        check("coll_same_r2", 32'(dbg_data), 32'h3333);
        mdl_rf[2] = 16'h3333;
        expect_idle_next("coll_same");

        // Different addresses: both writes land.
        coll_op("coll_diff", 3'd3, 3'd6, 16'h5555);
        dbg_addr = 3'd3;
        #1;
        check("coll_diff_r3", 32'(dbg_data), 32'h4444);
        dbg_addr = 3'd6;
        #1;
        check("coll_diff_r6", 32'(dbg_data), 32'h5555);
        expect_idle_next("coll_diff");

        // Reset during ITER cycle 5 of a MUL.
        @(posedge clk);
        #1;
        op_valid  = 1'b1;
        op_fsel   = 4'd11;
        op_src1   = 3'd1;
        op_src2   = 3'd2;
        op_dst    = 3'd7;
        op_imm_en = 1'b0;
        @(posedge clk);
        #1 op_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("mrst_ready", 32'(op_ready), 32'd1);
        check("mrst_valid", 32'(res_valid), 32'd0);
        check("mrst_data", 32'(res_data), 32'd0);
        check("mrst_flags", 32'(flags_now()), 32'd0);
        for (int i = 0; i < NREGS; i++) begin
            dbg_addr = 3'(i);
            #1;
            check($sformatf("mrst_r%0d", i), 32'(dbg_data), 32'd0);
        end
        pulses = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (res_valid) pulses++;
        end
        check("mrst_no_pulse", 32'(pulses), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
